// File: rtl/esm_instr_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : esm_pkg
//  Description : Shared types and helpers for the ESM instruction buffer.
//                Holds the per-slot lifecycle enum and the index-width helper
//                used by the interface, the buffer and the priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package esm_pkg;

    // Lifecycle of one buffer slot:
    // FREE -> WAIT (allocated) -> READY (core reported) -> ISSUED (in output reg) -> FREE
    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_READY  = 2'd2,
        SLOT_ISSUED = 2'd3
    } slot_state_e;

    // Slot index width for a buffer of n slots (never narrower than one bit).
    function automatic int esm_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/esm_instr_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : esm_instr_buffer_if
//  Description : Bundle of all buffer-facing signals: upstream instruction
//                input, allocation/pass-through to the dependency core, ready
//                reports from the core, downstream issue handshake, status.
//  Ports       : master - upstream/core/downstream side (drives in_*,
//                         ida_ready_*, out_ready)
//                slave  - the instruction buffer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface esm_instr_buffer_if #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16
);
    import esm_pkg::*;

    localparam int IW = esm_iw(bs);

    // upstream
    logic                       in_valid;
    logic [Instr_word_size-1:0] in_instr;
    logic                       in_alusrc;
    logic                       in_regwrite;
    logic                       in_ready;
    // allocation towards the dependency core
    logic                       ida_alloc;
    logic [Instr_word_size-1:0] ida_instr;
    logic                       ida_alusrc;
    logic                       ida_regwrite;
    logic [IW-1:0]              ida_buffer_index;
    // ready reports from the dependency core
    logic                       ida_ready_valid;
    logic [IW-1:0]              ida_ready_index;
    // downstream issue
    logic                       out_valid;
    logic [Instr_word_size-1:0] out_instr;
    logic [IW-1:0]              out_index;
    logic                       out_ready;
    // status
    logic [IW:0]                count;
    logic                       err;

    modport master (
        output in_valid, in_instr, in_alusrc, in_regwrite,
        output ida_ready_valid, ida_ready_index, out_ready,
        input  in_ready, ida_alloc, ida_instr, ida_alusrc, ida_regwrite,
        input  ida_buffer_index, out_valid, out_instr, out_index, count, err
    );

    modport slave (
        input  in_valid, in_instr, in_alusrc, in_regwrite,
        input  ida_ready_valid, ida_ready_index, out_ready,
        output in_ready, ida_alloc, ida_instr, ida_alusrc, ida_regwrite,
        output ida_buffer_index, out_valid, out_instr, out_index, count, err
    );

endinterface
`default_nettype wire

// File: rtl/esm_instr_buffer_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : esm_prio_enc
//  Description : Lowest-set-bit priority encoder.
//  Ports       : req_i   - request vector (N bits)
//                found_o - at least one bit of req_i is set
//                idx_o   - index of the lowest set bit (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module esm_prio_enc
    import esm_pkg::*;
#(
    parameter int N = 16,
    parameter int W = esm_iw(N)
) (
    input  wire logic [N-1:0] req_i,
    output logic              found_o,
    output logic [W-1:0]      idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/esm_instr_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : esm_instr_buffer
//  Description : Instruction staging buffer in front of the ESM dependency
//                core. Allocates the lowest free slot for each accepted
//                instruction, holds it until the core reports the slot ready,
//                then issues the lowest ready slot through a one-entry output
//                register with a valid/ready handshake and frees the slot.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - esm_instr_buffer_if.slave (upstream, core, downstream,
//                        count and sticky err)
//  Revision    : 1.0 - initial release
// ============================================================================
module esm_instr_buffer
    import esm_pkg::*;
#(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    esm_instr_buffer_if.slave bus
);

    localparam int             IW       = esm_iw(bs);
    localparam int             CW       = IW + 1;
    localparam logic [CW-1:0]  c_BS_CNT = CW'(bs);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    slot_state_e                slot_state_q [bs];
    slot_state_e                slot_state_d [bs];
    // Only the word is held; the control bits are consumed by the core at
    // allocation time and are not needed downstream.
    logic [Instr_word_size-1:0] slot_instr_q [bs];

    logic [CW-1:0]              count_q,     count_d;
    logic                       out_valid_q, out_valid_d;
    logic [Instr_word_size-1:0] out_instr_q, out_instr_d;
    logic [IW-1:0]              out_index_q, out_index_d;
    logic                       err_q,       err_d;

    // ------------------------------------------------------------------
    // Slot selection
    // ------------------------------------------------------------------
    logic [bs-1:0] w_free_vec;
    logic [bs-1:0] w_ready_vec;
    logic          w_free_found;
    logic          w_ready_found;
    logic [IW-1:0] w_free_idx;
    logic [IW-1:0] w_ready_idx;

    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < bs; i++) begin
            w_free_vec[i]  = (slot_state_q[i] == SLOT_FREE);
            w_ready_vec[i] = (slot_state_q[i] == SLOT_READY);
        end
    end

    esm_prio_enc #(.N(bs), .W(IW)) u_free_enc (
        .req_i   (w_free_vec),
        .found_o (w_free_found),
        .idx_o   (w_free_idx)
    );

    esm_prio_enc #(.N(bs), .W(IW)) u_ready_enc (
        .req_i   (w_ready_vec),
        .found_o (w_ready_found),
        .idx_o   (w_ready_idx)
    );

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;
    logic w_drain;
    logic w_load;
    logic w_mark_ok;

    assign w_in_ready = (count_q < c_BS_CNT) && w_free_found;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drain    = out_valid_q && bus.out_ready;
    // Reloading on the draining edge keeps one issue per cycle.
    assign w_load     = w_ready_found && (!out_valid_q || w_drain);
    // Judged on the pre-edge state: a slot being allocated this edge is
    // still FREE, so a ready report for it is an error.
    assign w_mark_ok  = (slot_state_q[bus.ida_ready_index] == SLOT_WAIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // The slots touched by drain, load, mark and accept are in distinct
    // states (ISSUED, READY, WAIT, FREE), so the updates never collide.
    always_comb begin
        slot_state_d = slot_state_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_index_d  = out_index_q;
        err_d        = err_q;

        if (w_drain) begin
            slot_state_d[out_index_q] = SLOT_FREE;
            out_valid_d               = 1'b0;
        end

        if (w_load) begin
            slot_state_d[w_ready_idx] = SLOT_ISSUED;
            out_valid_d               = 1'b1;
            out_instr_d               = slot_instr_q[w_ready_idx];
            out_index_d               = w_ready_idx;
        end

        if (bus.ida_ready_valid) begin
            if (w_mark_ok) begin
                slot_state_d[bus.ida_ready_index] = SLOT_READY;
            end else begin
                err_d = 1'b1;
            end
        end

        if (w_accept) begin
            slot_state_d[w_free_idx] = SLOT_WAIT;
        end

        case ({w_accept, w_drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < bs; i++) begin
                slot_state_q[i] <= SLOT_FREE;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_index_q <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_state_q <= slot_state_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_index_q  <= out_index_d;
            err_q        <= err_d;
        end
    end

    // Payload storage is qualified by slot state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            slot_instr_q[w_free_idx] <= bus.in_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready         = w_in_ready;
        bus.ida_alloc        = w_accept;
        bus.ida_instr        = bus.in_instr;
        bus.ida_alusrc       = bus.in_alusrc;
        bus.ida_regwrite     = bus.in_regwrite;
        bus.ida_buffer_index = w_free_idx;
        bus.out_valid        = out_valid_q;
        bus.out_instr        = out_instr_q;
        bus.out_index        = out_index_q;
        bus.count            = count_q;
        bus.err              = err_q;
    end

endmodule
`default_nettype wire
